// File: rtl/lpif_rx_marker_align.sv
// LPIF receive marker checker and word-alignment lock FSM.
// Optional strobe qualification: define LPIF_RX_ALIGN_STROBE_CHECK_EN.
module lpif_rx_marker_align #(
    parameter int MARKER_WIDTH = 4,
    parameter int LOCK_COUNT   = 8,
    parameter int UNLOCK_COUNT = 4
) (
    input  logic                    clk_wr,
    input  logic                    rst_wr_n,
    input  logic                    rx_online_delay,
    input  logic                    rx_word_valid,
    input  logic [MARKER_WIDTH-1:0] rx_mrk_userbit,
    input  logic                    rx_stb_userbit,
    input  logic                    err_clr,
    output logic                    rx_aligned,
    output logic [1:0]              rx_align_state,
    output logic                    rx_align_err,
    output logic [15:0]             err_count,
    output logic [31:0]             rx_align_debug_status
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2,
        SLIP   = 2'd3
    } state_t;

    localparam logic [MARKER_WIDTH-1:0] MRK_GOOD =
        MARKER_WIDTH'(1) << (MARKER_WIDTH - 1);
    localparam logic [7:0] LOCK_TH   = 8'(LOCK_COUNT);
    localparam logic [7:0] UNLOCK_TH = 8'(UNLOCK_COUNT);

    state_t     state;
    logic [7:0] good_cnt;
    logic [7:0] bad_cnt;
    logic       online_q;
    logic       word_good;
    logic       word_bad;
    logic       err_inc;

`ifdef LPIF_RX_ALIGN_STROBE_CHECK_EN
    assign word_good = rx_word_valid
                    && (rx_mrk_userbit == MRK_GOOD)
                    && rx_stb_userbit;
`else
    logic unused_stb;
    assign unused_stb = rx_stb_userbit;
    assign word_good  = rx_word_valid
                     && (rx_mrk_userbit == MRK_GOOD);
`endif

    assign word_bad = rx_word_valid && !word_good;

    // Going offline suppresses the error accounting of the same cycle.
    assign err_inc = rx_online_delay && word_bad
                  && ((state == LOCKED) || (state == SLIP));

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            state        <= IDLE;
            good_cnt     <= 8'd0;
            bad_cnt      <= 8'd0;
            rx_aligned   <= 1'b0;
            rx_align_err <= 1'b0;
            online_q     <= 1'b0;
        end else begin
            rx_align_err <= 1'b0;
            online_q     <= rx_online_delay;
            if (!rx_online_delay) begin
                state      <= IDLE;
                good_cnt   <= 8'd0;
                bad_cnt    <= 8'd0;
                rx_aligned <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state    <= HUNT;
                        good_cnt <= 8'd0;
                        bad_cnt  <= 8'd0;
                    end
                    HUNT: begin
                        if (word_good) begin
                            if (good_cnt + 8'd1 == LOCK_TH) begin
                                state      <= LOCKED;
                                rx_aligned <= 1'b1;
                                good_cnt   <= 8'd0;
                                bad_cnt    <= 8'd0;
                            end else begin
                                good_cnt <= good_cnt + 8'd1;
                            end
                        end else if (word_bad) begin
                            good_cnt <= 8'd0;
                        end
                    end
                    LOCKED: begin
                        if (word_bad) begin
                            rx_align_err <= 1'b1;
                            if (UNLOCK_TH == 8'd1) begin
                                state      <= HUNT;
                                rx_aligned <= 1'b0;
                                good_cnt   <= 8'd0;
                            end else begin
                                state   <= SLIP;
                                bad_cnt <= 8'd1;
                            end
                        end
                    end
                    SLIP: begin
                        if (word_good) begin
                            state   <= LOCKED;
                            bad_cnt <= 8'd0;
                        end else if (word_bad) begin
                            rx_align_err <= 1'b1;
                            if (bad_cnt + 8'd1 == UNLOCK_TH) begin
                                state      <= HUNT;
                                rx_aligned <= 1'b0;
                                good_cnt   <= 8'd0;
                                bad_cnt    <= 8'd0;
                            end else begin
                                bad_cnt <= bad_cnt + 8'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            err_count <= 16'd0;
        end else if (err_clr) begin
            err_count <= 16'd0;
        end else if (err_inc && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end

    assign rx_align_state = state;
    assign rx_align_debug_status =
        {12'h0, online_q, rx_aligned, rx_align_state, err_count};

endmodule

// File: tb/tb_lpif_rx_marker_align.sv
// Self-checking bench for lpif_rx_marker_align: vector table,
// directed corner sequences and random stimulus against a model.
module tb_lpif_rx_marker_align;

    localparam int LOCK   = 8;
    localparam int UNLOCK = 4;
`ifdef LPIF_RX_ALIGN_STROBE_CHECK_EN
    localparam bit STB_EN = 1'b1;
`else
    localparam bit STB_EN = 1'b0;
`endif

    logic        clk_wr = 1'b0;
    logic        rst_wr_n;
    logic        online, vld, stb, clr;
    logic [3:0]  mrk;
    logic        aligned, err;
    logic [1:0]  state;
    logic [15:0] ecnt;
    logic [31:0] dbg;

    logic        online2, vld2, stb2, clr2;
    logic [3:0]  mrk2;
    logic        aligned2, err2;
    logic [1:0]  state2;
    logic [15:0] ecnt2;
    logic [31:0] dbg2;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk_wr = ~clk_wr;

    lpif_rx_marker_align #(
        .MARKER_WIDTH(4), .LOCK_COUNT(LOCK), .UNLOCK_COUNT(UNLOCK)
    ) dut (
        .clk_wr(clk_wr), .rst_wr_n(rst_wr_n),
        .rx_online_delay(online), .rx_word_valid(vld),
        .rx_mrk_userbit(mrk), .rx_stb_userbit(stb),
        .err_clr(clr), .rx_aligned(aligned),
        .rx_align_state(state), .rx_align_err(err),
        .err_count(ecnt), .rx_align_debug_status(dbg)
    );

    lpif_rx_marker_align #(
        .MARKER_WIDTH(4), .LOCK_COUNT(1), .UNLOCK_COUNT(255)
    ) dut2 (
        .clk_wr(clk_wr), .rst_wr_n(rst_wr_n),
        .rx_online_delay(online2), .rx_word_valid(vld2),
        .rx_mrk_userbit(mrk2), .rx_stb_userbit(stb2),
        .err_clr(clr2), .rx_aligned(aligned2),
        .rx_align_state(state2), .rx_align_err(err2),
        .err_count(ecnt2), .rx_align_debug_status(dbg2)
    );

    // Reference model: lock flag plus run lengths of good/bad words.
    bit m_active, m_locked, m_err, m_onq;
    int m_good, m_bad, m_errcnt;

    function automatic bit is_good(logic [3:0] m, logic s);
        return (m == 4'b1000) && (s || !STB_EN);
    endfunction

    function automatic int m_state();
        if (!m_active) return 0;
        if (!m_locked) return 1;
        return (m_bad > 0) ? 3 : 2;
    endfunction

    task automatic model_reset();
        m_active = 0; m_locked = 0; m_err = 0; m_onq = 0;
        m_good = 0; m_bad = 0; m_errcnt = 0;
    endtask

    task automatic model_step(input logic o, input logic v,
                              input logic [3:0] m, input logic s,
                              input logic c);
        bit inc = 0;
        m_err = 0;
        if (!o) begin
            m_active = 0; m_locked = 0; m_good = 0; m_bad = 0;
        end else if (!m_active) begin
            m_active = 1; m_good = 0;
        end else if (v) begin
            if (!m_locked) begin
                if (is_good(m, s)) begin
                    m_good++;
                    if (m_good == LOCK) begin
                        m_locked = 1; m_bad = 0;
                    end
                end else begin
                    m_good = 0;
                end
            end else if (is_good(m, s)) begin
                m_bad = 0;
            end else begin
                inc = 1; m_err = 1; m_bad++;
                if (m_bad == UNLOCK) begin
                    m_locked = 0; m_bad = 0; m_good = 0;
                end
            end
        end
        if (c) m_errcnt = 0;
        else if (inc && m_errcnt < 65535) m_errcnt++;
        m_onq = o;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic o, input logic v,
                        input logic [3:0] m, input logic s,
                        input logic c);
        logic [31:0] exp_dbg;
        online = o; vld = v; mrk = m; stb = s; clr = c;
        @(posedge clk_wr);
        model_step(o, v, m, s, c);
        #1;
        exp_dbg = {12'h0, m_onq, m_locked, 2'(m_state()), 16'(m_errcnt)};
        check("state", 32'(state), 32'(m_state()));
        check("aligned", 32'(aligned), 32'(m_locked));
        check("err_pulse", 32'(err), 32'(m_err));
        check("err_count", 32'(ecnt), 32'(m_errcnt));
        check("debug", dbg, exp_dbg);
    endtask

    typedef struct {
        logic        on, vd;
        logic [3:0]  mk;
        logic        sb, cl;
        logic [1:0]  st;
        logic        al, er;
        logic [15:0] ec;
    } vec_t;

    vec_t tv[$];

    function automatic void add(logic o, logic v, logic [3:0] m,
                                logic s, logic c, logic [1:0] st,
                                logic al, logic er, logic [15:0] ec);
        vec_t t;
        t.on = o; t.vd = v; t.mk = m; t.sb = s; t.cl = c;
        t.st = st; t.al = al; t.er = er; t.ec = ec;
        tv.push_back(t);
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int bads, run;
        // Acquire, invalid hold, slip recovery, loss of lock
        add(1, 0, 4'h8, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(1, 1, 4'h8, 1, 0, 1, 0, 0, 0);
        add(1, 1, 4'h8, 1, 0, 2, 1, 0, 0);
        add(1, 0, 4'h4, 1, 0, 2, 1, 0, 0);
        add(1, 1, 4'h4, 1, 0, 3, 1, 1, 1);
        add(1, 1, 4'h9, 1, 0, 3, 1, 1, 2);
        add(1, 1, 4'h0, 1, 0, 3, 1, 1, 3);
        add(1, 1, 4'h8, 1, 0, 2, 1, 0, 3);
        add(1, 1, 4'hC, 1, 0, 3, 1, 1, 4);
        add(1, 1, 4'h4, 1, 0, 3, 1, 1, 5);
        add(1, 1, 4'h4, 1, 0, 3, 1, 1, 6);
        add(1, 1, 4'h4, 1, 0, 1, 0, 1, 7);
        // Hunt restart: lock only after 8 fresh good words
        for (int i = 0; i < 5; i++) add(1, 1, 4'h8, 1, 0, 1, 0, 0, 7);
        add(1, 1, 4'h4, 1, 0, 1, 0, 0, 7);
        for (int i = 0; i < 7; i++) add(1, 1, 4'h8, 1, 0, 1, 0, 0, 7);
        add(1, 1, 4'h8, 1, 0, 2, 1, 0, 7);
        // Clear beats increment; offline abort from SLIP
        add(1, 1, 4'h4, 1, 0, 3, 1, 1, 8);
        add(1, 1, 4'h4, 1, 1, 3, 1, 1, 0);
        add(1, 1, 4'h4, 1, 0, 3, 1, 1, 1);
        add(0, 1, 4'h4, 1, 0, 0, 0, 0, 1);
        add(0, 0, 4'h0, 0, 0, 0, 0, 0, 1);

        rst_wr_n = 1'b0;
        online = 0; vld = 0; mrk = 0; stb = 0; clr = 0;
        online2 = 0; vld2 = 0; mrk2 = 0; stb2 = 0; clr2 = 0;
        model_reset();
        repeat (3) @(posedge clk_wr);
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_aligned", 32'(aligned), 0);
        check("rst_err", 32'(err), 0);
        check("rst_err_count", 32'(ecnt), 0);
        check("rst_debug", dbg, 0);
        @(negedge clk_wr);
        rst_wr_n = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].on, tv[i].vd, tv[i].mk, tv[i].sb, tv[i].cl);
            check($sformatf("tv%0d_state", i), 32'(state), 32'(tv[i].st));
            check($sformatf("tv%0d_aligned", i), 32'(aligned),
                  32'(tv[i].al));
            check($sformatf("tv%0d_err", i), 32'(err), 32'(tv[i].er));
            check($sformatf("tv%0d_err_count", i), 32'(ecnt),
                  32'(tv[i].ec));
        end

        // Strobe qualification: marker right, strobe low
        step(1, 0, 4'h0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 1, 4'h8, 0, 0);
        check("stb_state", 32'(state), STB_EN ? 32'd1 : 32'd2);
        check("stb_aligned", 32'(aligned), STB_EN ? 32'd0 : 32'd1);

        // Asynchronous reset while locked
        step(0, 0, 4'h0, 0, 0);
        step(1, 0, 4'h0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 1, 4'h8, 1, 0);
        step(1, 1, 4'h4, 1, 0);
        @(negedge clk_wr);
        online = 0; vld = 0;
        rst_wr_n = 1'b0;
        #1;
        model_reset();
        check("arst_state", 32'(state), 0);
        check("arst_aligned", 32'(aligned), 0);
        check("arst_err_count", 32'(ecnt), 0);
        check("arst_debug", dbg, 0);
        @(negedge clk_wr);
        rst_wr_n = 1'b1;

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            logic o, v, s, c;
            logic [3:0] m;
            o = ($urandom_range(0, 199) != 0);
            v = ($urandom_range(0, 4) != 0);
            m = ($urandom_range(0, 99) < 90) ? 4'h8
                                             : 4'($urandom_range(0, 15));
            s = ($urandom_range(0, 19) != 0);
            c = ($urandom_range(0, 99) == 0);
            step(o, v, m, s, c);
        end
        step(0, 0, 4'h0, 0, 0);

        // Saturation on the LOCK_COUNT=1 / UNLOCK_COUNT=255 instance
        online2 = 1; vld2 = 0; stb2 = 1;
        @(posedge clk_wr); #1;
        check("sat_hunt", 32'(state2), 1);
        vld2 = 1; mrk2 = 4'h8;
        @(posedge clk_wr); #1;
        check("sat_lock1", 32'(state2), 2);
        bads = 0; run = 0;
        while (bads < 65537) begin
            if (run == 254) begin
                mrk2 = 4'h8; run = 0;
            end else begin
                mrk2 = 4'h4; run++; bads++;
            end
            @(posedge clk_wr); #1;
            if (run != 0 && bads == 65534)
                check("sat_fffe", 32'(ecnt2), 32'hFFFE);
            if (run != 0 && bads == 65535)
                check("sat_ffff", 32'(ecnt2), 32'hFFFF);
        end
        check("sat_hold", 32'(ecnt2), 32'hFFFF);
        check("sat_aligned", 32'(aligned2), 1);
        mrk2 = 4'h4; clr2 = 1;
        @(posedge clk_wr); #1;
        check("sat_clr", 32'(ecnt2), 0);
        check("sat_clr_err", 32'(err2), 1);
        clr2 = 0; online2 = 0; vld2 = 0;
        @(posedge clk_wr); #1;
        check("sat_offline", 32'(state2), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/lpif_rx_marker_align.md
# lpif_rx_marker_align

Receive-side marker checker and alignment-lock FSM for the LPIF asymmetric transport. It decodes the marker and strobe userbits that the transmit-side auto-sync logic inserts into each PHY word, and acquires and holds word alignment. It gates the receive online indication seen by the upstream concat/user-interface path and reports lock status and error counts for debug.

## Interface
Parameters:
- MARKER_WIDTH, 4, marker userbits per received word (4 = quarter rate, 2 = half rate).
- LOCK_COUNT, 8, consecutive good words required to declare lock; legal range 1..255.
- UNLOCK_COUNT, 4, consecutive bad words that drop lock; legal range 1..255.

Ports (clock and reset first):
- clk_wr  in  1  sole clock.
- rst_wr_n  in  1  asynchronous, active-low reset.
- rx_online_delay  in  1  delayed receive online from auto-sync; enables checking.
- rx_word_valid  in  1  a PHY word is present this cycle.
- rx_mrk_userbit  in  MARKER_WIDTH  marker bits extracted from the word, bit i = beat i.
- rx_stb_userbit  in  1  strobe bit extracted from the word.
- err_clr  in  1  synchronous clear of err_count.
- rx_aligned  out  1  lock achieved; gates the upstream push.
- rx_align_state  out  2  FSM state encoding.
- rx_align_err  out  1  one-cycle pulse for each bad word in LOCKED or SLIP.
- err_count  out  16  saturating bad-word count while locked.
- rx_align_debug_status  out  32  {12'h0, rx_online_delay, rx_aligned, rx_align_state, err_count}.

## Operation
- **Good word:** rx_word_valid=1 and rx_mrk_userbit is one-hot at bit MARKER_WIDTH-1. With the strobe check compiled in, rx_stb_userbit=1 is also required.
- **Bad word:** rx_word_valid=1 and the word is not good.
- Cycles with rx_word_valid=0 are ignored: no state change, and counters hold.
- **States** (encoding): IDLE=0, HUNT=1, LOCKED=2, SLIP=3.
  - IDLE: entered whenever rx_online_delay=0, from any state, with priority over everything else. On entry, good_cnt and bad_cnt are cleared. Moves to HUNT on the cycle after rx_online_delay rises.
  - HUNT: each good word increments good_cnt; each bad word clears good_cnt to 0. A good word that brings good_cnt to LOCK_COUNT moves the FSM to LOCKED.
  - LOCKED: a good word keeps the state. A bad word moves to SLIP with bad_cnt=1. If UNLOCK_COUNT=1, a bad word moves directly to HUNT instead.
  - SLIP: a good word returns to LOCKED and clears bad_cnt. A bad word increments bad_cnt. A bad word that brings bad_cnt to UNLOCK_COUNT moves to HUNT and clears good_cnt.
- rx_aligned=1 in LOCKED and in SLIP. It drops only on entry to HUNT or IDLE.
- err_count increments on every bad word in LOCKED or SLIP and saturates at 16'hFFFF.
- If err_clr and an increment occur in the same cycle, err_clr wins and the result is 0.
- err_count is not cleared by loss of lock.
- Counter widths are 8 bits and compare with ==. The counters never exceed their thresholds.

## Timing
- All outputs are registered. A word sampled in cycle N affects the outputs in cycle N+1.
- Reset values: rx_aligned=0, rx_align_state=0 (IDLE), rx_align_err=0, err_count=0, rx_align_debug_status=0. Internal counters also reset to 0.
- Minimum acquisition time from rx_online_delay rising is 1 + LOCK_COUNT valid cycles.
- rx_online_delay falling with a bad word in the same cycle: the FSM goes to IDLE, there is no rx_align_err pulse, and err_count does not increment.
- Reset asserted mid-lock: the block goes to the reset values immediately (asynchronous). Deassertion is used synchronously.

## Configuration
- LPIF_RX_ALIGN_STROBE_CHECK_EN defined: rx_stb_userbit=1 is part of the good-word qualification.
- LPIF_RX_ALIGN_STROBE_CHECK_EN undefined: rx_stb_userbit is ignored, and only the marker pattern qualifies a word.

## Test plan
- **Reset and acquire:** reset, then rx_online_delay=1, then 8 good words (mrk=4'b1000, stb=1) -> rx_aligned rises the cycle after the 8th word; state=2; err_count=0.
- **Hunt restart:** 5 good words, 1 bad (mrk=4'b0100), then 8 good -> lock only after the final 8th good word; no rx_align_err pulses during HUNT.
- **Slip recovery and loss:**
  - In LOCKED: 3 bad words, then 1 good -> state goes 3 then 2; rx_aligned stays 1; err_count=3.
  - Then 4 consecutive bad words -> state=1; rx_aligned=0; err_count=7.
- **Saturation and clear:** force 65540 bad words while locked (re-locking as needed) -> err_count holds at 16'hFFFF. Assert err_clr together with a bad word -> err_count=0.
- **Offline abort:** drop rx_online_delay while in SLIP with a bad word in the same cycle -> next cycle state=0, rx_aligned=0, no err pulse.
- **Strobe macro:** with LPIF_RX_ALIGN_STROBE_CHECK_EN, send 8 words with mrk=4'b1000 and stb=0 -> no lock. Without the macro, the same stimulus locks.
